// File: rtl/id_issue_pkg.sv
// Shared CPU definitions: RV32I major-opcode constants, immediate formats
// and the per-opcode decode table used by issue, ALU and control.
package id_issue_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_RS1  = 2'd1,
        OP1_PC   = 2'd2
    } op1_sel_e;

    typedef struct packed {
        logic      legal;
        imm_type_e imm_type;
        op1_sel_e  op1_sel;
        logic      op2_rs2;
        logic      use_rs1;
        logic      use_rs2;
        logic      rd_write;
        logic      mem_read;
        logic      mem_write;
    } decode_t;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  func3;
        logic        func7;
        logic [31:0] operand1;
        logic [31:0] operand2;
        logic [31:0] store_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } ex_entry_t;

    // Anything outside the nine supported major opcodes decodes as all-zero,
    // which reads as illegal with no side effects.
    function automatic decode_t decode_opcode(input logic [1:0] quad, input logic [4:0] opcode);
        decode_t d;
        d = '0;
        if (quad == 2'b11) begin
            case (opcode)
                OPC_OP: begin
                    d.legal = 1'b1; d.op1_sel = OP1_RS1; d.op2_rs2 = 1'b1;
                    d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.rd_write = 1'b1;
                end
                OPC_BRANCH: begin
                    d.legal = 1'b1; d.imm_type = IMM_B; d.op1_sel = OP1_RS1; d.op2_rs2 = 1'b1;
                    d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
                end
                OPC_OP_IMM, OPC_JALR: begin
                    d.legal = 1'b1; d.imm_type = IMM_I; d.op1_sel = OP1_RS1;
                    d.use_rs1 = 1'b1; d.rd_write = 1'b1;
                end
                OPC_LOAD: begin
                    d.legal = 1'b1; d.imm_type = IMM_I; d.op1_sel = OP1_RS1;
                    d.use_rs1 = 1'b1; d.rd_write = 1'b1; d.mem_read = 1'b1;
                end
                OPC_STORE: begin
                    d.legal = 1'b1; d.imm_type = IMM_S; d.op1_sel = OP1_RS1;
                    d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.mem_write = 1'b1;
                end
                OPC_AUIPC: begin
                    d.legal = 1'b1; d.imm_type = IMM_U; d.op1_sel = OP1_PC; d.rd_write = 1'b1;
                end
                OPC_JAL: begin
                    d.legal = 1'b1; d.imm_type = IMM_J; d.op1_sel = OP1_PC; d.rd_write = 1'b1;
                end
                OPC_LUI: begin
                    d.legal = 1'b1; d.imm_type = IMM_U; d.op1_sel = OP1_ZERO; d.rd_write = 1'b1;
                end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

    function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] i);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{21{i[31]}}, i[30:20]};
            IMM_S:   imm = {{21{i[31]}}, i[30:25], i[11:7]};
            IMM_B:   imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            IMM_J:   imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_issue_reg_file.sv
// Integer register file x1..x31 with two combinational read ports and one
// write port; a same-cycle write is forwarded to matching reads.
module reg_file
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_reg [1:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs_reg[waddr] <= wdata;
        end
    end

    // x0 is hard-wired; the array has no storage behind address 0.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != 5'd0) begin
            rdata1 = (we && waddr == raddr1) ? wdata : regs_reg[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != 5'd0) begin
            rdata2 = (we && waddr == raddr2) ? wdata : regs_reg[raddr2];
        end
    end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: decodes the offered RV32I word, reads operands, checks
// the busy scoreboard and hands one entry at a time to execute.
module id_issue
    import id_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [4:0]  ex_opcode,
    output logic [2:0]  ex_func3,
    output logic        ex_func7,
    output logic [31:0] ex_operand1,
    output logic [31:0] ex_operand2,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_illegal
);

    decode_t     dec;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    ex_entry_t   entry_next;
    ex_entry_t   ex_reg;
    logic        ex_valid_reg;
    logic        ex_valid_next;
    logic [31:0] busy_reg;
    logic [31:0] busy_next;
    logic [31:0] busy_eff;
    logic        ex_writes;
    logic        rs1_hz;
    logic        rs2_hz;
    logic        rd_hz;
    logic        hazard;
    logic        accept;
    logic        issue;

    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign rd  = if_instr[11:7];
    assign dec = decode_opcode(if_instr[1:0], if_instr[6:2]);
    assign imm = gen_imm(dec.imm_type, if_instr);

    reg_file u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    // Per-register scoreboard: a writeback clears, an issue sets, and the
    // issue wins when both name the same register in one cycle.
    assign busy_eff[0]  = busy_reg[0];
    assign busy_next[0] = 1'b0;
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
        assign busy_eff[gi]  = busy_reg[gi] && !(wb_en && wb_rd == 5'(gi));
        assign busy_next[gi] = (issue && ex_reg.rd == 5'(gi)) || busy_eff[gi];
    end

    assign ex_writes = ex_valid_reg && ex_reg.reg_write;

    always_comb begin
        rs1_hz = dec.use_rs1 && rs1 != 5'd0 && (busy_eff[rs1] || (ex_writes && ex_reg.rd == rs1));
        rs2_hz = dec.use_rs2 && rs2 != 5'd0 && (busy_eff[rs2] || (ex_writes && ex_reg.rd == rs2));
        rd_hz  = dec.rd_write && rd != 5'd0 && (busy_eff[rd] || (ex_writes && ex_reg.rd == rd));
        hazard = if_valid && (rs1_hz || rs2_hz || rd_hz);
    end

    assign id_ready = (!ex_valid_reg || ex_ready) && !hazard;
    assign accept   = if_valid && id_ready && !flush;
    assign issue    = ex_writes && ex_ready && !flush;

    always_comb begin
        entry_next            = '0;
        entry_next.opcode     = if_instr[6:2];
        entry_next.func3      = if_instr[14:12];
        entry_next.func7      = if_instr[30];
        entry_next.imm        = imm;
        entry_next.pc         = if_pc;
        entry_next.rd         = rd;
        entry_next.store_data = rs2_data;
        case (dec.op1_sel)
            OP1_RS1: entry_next.operand1 = rs1_data;
            OP1_PC:  entry_next.operand1 = if_pc;
            default: entry_next.operand1 = '0;
        endcase
        entry_next.operand2   = dec.op2_rs2 ? rs2_data : imm;
        entry_next.reg_write  = dec.rd_write && rd != 5'd0;
        entry_next.mem_read   = dec.mem_read;
        entry_next.mem_write  = dec.mem_write;
        entry_next.illegal    = !dec.legal;
    end

    always_comb begin
        ex_valid_next = ex_valid_reg;
        if (flush) begin
            ex_valid_next = 1'b0;
        end else if (accept) begin
            ex_valid_next = 1'b1;
        end else if (ex_ready) begin
            ex_valid_next = 1'b0;
        end
    end

    // The payload only loads on acceptance, so it holds while execute stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg <= 1'b0;
            ex_reg       <= '0;
            busy_reg     <= '0;
        end else begin
            ex_valid_reg <= ex_valid_next;
            busy_reg     <= busy_next;
            if (accept) begin
                ex_reg <= entry_next;
            end
        end
    end

    assign ex_valid      = ex_valid_reg;
    assign ex_opcode     = ex_reg.opcode;
    assign ex_func3      = ex_reg.func3;
    assign ex_func7      = ex_reg.func7;
    assign ex_operand1   = ex_reg.operand1;
    assign ex_operand2   = ex_reg.operand2;
    assign ex_store_data = ex_reg.store_data;
    assign ex_imm        = ex_reg.imm;
    assign ex_pc         = ex_reg.pc;
    assign ex_rd         = ex_reg.rd;
    assign ex_reg_write  = ex_reg.reg_write;
    assign ex_mem_read   = ex_reg.mem_read;
    assign ex_mem_write  = ex_reg.mem_write;
    assign ex_illegal    = ex_reg.illegal;

endmodule

// File: tb/tb_id_issue.sv
// Directed bench for id_issue: each task drives one scenario and compares the
// execute-side outputs against hand-encoded instructions and values.
module tb_id_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic        ex_func7;
    logic [31:0] ex_operand1;
    logic [31:0] ex_operand2;
    logic [31:0] ex_store_data;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_issue dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
        .ex_func3(ex_func3), .ex_func7(ex_func7), .ex_operand1(ex_operand1),
        .ex_operand2(ex_operand2), .ex_store_data(ex_store_data), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b0;
        #2;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL reset_id_ready got %b want 1", id_ready); end
        n_cmp++; if (ex_operand1 !== 32'h0) begin n_bad++; $display("FAIL reset_op1 got %h want 0", ex_operand1); end
        n_cmp++; if (ex_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", ex_pc); end
        step();
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_addi();
        ex_ready = 1'b1;
        offer(32'h00500093, 32'h0);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL addi_ready got %b want 1", id_ready); end
        step();
        if_valid = 1'b0;
        n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid got %b want 1", ex_valid); end
        n_cmp++; if (ex_opcode !== 5'b00100) begin n_bad++; $display("FAIL addi_opcode got %b want 00100", ex_opcode); end
        n_cmp++; if (ex_operand1 !== 32'd0) begin n_bad++; $display("FAIL addi_op1 got %h want 0", ex_operand1); end
        n_cmp++; if (ex_operand2 !== 32'd5) begin n_bad++; $display("FAIL addi_op2 got %h want 5", ex_operand2); end
        n_cmp++; if (ex_rd !== 5'd1) begin n_bad++; $display("FAIL addi_rd got %0d want 1", ex_rd); end
        n_cmp++; if (ex_reg_write !== 1'b1) begin n_bad++; $display("FAIL addi_regwr got %b want 1", ex_reg_write); end
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL addi_drain got %b want 0", ex_valid); end
        $display("addi x1,x0,5 issued");
    endtask

    task automatic test_raw_hazard();
        offer(32'h002081B3, 32'h4);
        #1;
        n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL raw_blocked0 got %b want 0", id_ready); end
        step();
        n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL raw_blocked1 got %b want 0", id_ready); end
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL raw_noaccept got %b want 0", ex_valid); end
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL raw_wb_ready got %b want 1", id_ready); end
        step();
        wb_en = 1'b0; if_valid = 1'b0;
        n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL raw_valid got %b want 1", ex_valid); end
        n_cmp++; if (ex_operand1 !== 32'd7) begin n_bad++; $display("FAIL raw_op1 got %h want 7", ex_operand1); end
        n_cmp++; if (ex_operand2 !== 32'd0) begin n_bad++; $display("FAIL raw_op2 got %h want 0", ex_operand2); end
        n_cmp++; if (ex_rd !== 5'd3) begin n_bad++; $display("FAIL raw_rd got %0d want 3", ex_rd); end
        n_cmp++; if (ex_opcode !== 5'b01100) begin n_bad++; $display("FAIL raw_opcode got %b want 01100", ex_opcode); end
        step();
        writeback(5'd3, 32'd7);
        $display("add x3,x1,x2 issued after bypass");
    endtask

    task automatic test_stall();
        ex_ready = 1'b0;
        offer(32'h02000113, 32'h8);
        step();
        offer(32'h123452B7, 32'hC);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d_ready got %b want 0", k, id_ready); end
            n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL stall%0d_valid got %b want 1", k, ex_valid); end
            n_cmp++; if (ex_operand2 !== 32'h20) begin n_bad++; $display("FAIL stall%0d_op2 got %h want 20", k, ex_operand2); end
            n_cmp++; if (ex_rd !== 5'd2) begin n_bad++; $display("FAIL stall%0d_rd got %0d want 2", k, ex_rd); end
            n_cmp++; if (ex_pc !== 32'h8) begin n_bad++; $display("FAIL stall%0d_pc got %h want 8", k, ex_pc); end
            step();
        end
        ex_ready = 1'b1;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", id_ready); end
        step();
        if_valid = 1'b0;
        n_cmp++; if (ex_opcode !== 5'b01101) begin n_bad++; $display("FAIL lui_opcode got %b want 01101", ex_opcode); end
        n_cmp++; if (ex_operand1 !== 32'h0) begin n_bad++; $display("FAIL lui_op1 got %h want 0", ex_operand1); end
        n_cmp++; if (ex_operand2 !== 32'h12345000) begin n_bad++; $display("FAIL lui_op2 got %h want 12345000", ex_operand2); end
        n_cmp++; if (ex_rd !== 5'd5) begin n_bad++; $display("FAIL lui_rd got %0d want 5", ex_rd); end
        step();
        writeback(5'd2, 32'h20);
        writeback(5'd5, 32'h12345000);
        $display("stall held 3 cycles, lui issued back-to-back");
    endtask

    task automatic test_branch_store_load();
        ex_ready = 1'b1;
        offer(32'hFE208CE3, 32'h100);
        step();
        offer(32'hFE50AE23, 32'h104);
        n_cmp++; if (ex_imm !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL beq_imm got %h want fffffff8", ex_imm); end
        n_cmp++; if (ex_operand1 !== 32'd7) begin n_bad++; $display("FAIL beq_op1 got %h want 7", ex_operand1); end
        n_cmp++; if (ex_operand2 !== 32'h20) begin n_bad++; $display("FAIL beq_op2 got %h want 20", ex_operand2); end
        n_cmp++; if (ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL beq_regwr got %b want 0", ex_reg_write); end
        n_cmp++; if (ex_pc !== 32'h100) begin n_bad++; $display("FAIL beq_pc got %h want 100", ex_pc); end
        step();
        offer(32'h00412583, 32'h108);
        n_cmp++; if (ex_imm !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL sw_imm got %h want fffffffc", ex_imm); end
        n_cmp++; if (ex_store_data !== 32'h12345000) begin n_bad++; $display("FAIL sw_data got %h want 12345000", ex_store_data); end
        n_cmp++; if (ex_mem_write !== 1'b1) begin n_bad++; $display("FAIL sw_memwr got %b want 1", ex_mem_write); end
        n_cmp++; if (ex_func3 !== 3'b010) begin n_bad++; $display("FAIL sw_func3 got %b want 010", ex_func3); end
        step();
        if_valid = 1'b0;
        n_cmp++; if (ex_operand1 !== 32'h20) begin n_bad++; $display("FAIL lw_op1 got %h want 20", ex_operand1); end
        n_cmp++; if (ex_operand2 !== 32'h4) begin n_bad++; $display("FAIL lw_op2 got %h want 4", ex_operand2); end
        n_cmp++; if (ex_mem_read !== 1'b1) begin n_bad++; $display("FAIL lw_memrd got %b want 1", ex_mem_read); end
        n_cmp++; if (ex_mem_write !== 1'b0) begin n_bad++; $display("FAIL lw_memwr got %b want 0", ex_mem_write); end
        step();
        writeback(5'd11, 32'h55);
        $display("beq, sw, lw issued");
    endtask

    task automatic test_jal_ex_hazard();
        offer(32'h010000EF, 32'h200);
        step();
        offer(32'h00108313, 32'h204);
        n_cmp++; if (ex_operand1 !== 32'h200) begin n_bad++; $display("FAIL jal_op1 got %h want 200", ex_operand1); end
        n_cmp++; if (ex_operand2 !== 32'd16) begin n_bad++; $display("FAIL jal_op2 got %h want 10", ex_operand2); end
        #1;
        n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL exrd_hazard got %b want 0", id_ready); end
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL exrd_noaccept got %b want 0", ex_valid); end
        n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL busy_hazard got %b want 0", id_ready); end
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h204;
        step();
        wb_en = 1'b0; if_valid = 1'b0;
        n_cmp++; if (ex_operand1 !== 32'h204) begin n_bad++; $display("FAIL jal_dep_op1 got %h want 204", ex_operand1); end
        n_cmp++; if (ex_rd !== 5'd6) begin n_bad++; $display("FAIL jal_dep_rd got %0d want 6", ex_rd); end
        step();
        writeback(5'd6, 32'h205);
        $display("jal then dependent addi issued");
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        offer(32'h00300393, 32'h300);
        step();
        offer(32'h00400413, 32'h304);
        ex_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", ex_valid); end
        offer(32'h00038493, 32'h308);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL flush_nobusy got %b want 1", id_ready); end
        step();
        if_valid = 1'b0;
        n_cmp++; if (ex_rd !== 5'd9) begin n_bad++; $display("FAIL flush_next_rd got %0d want 9", ex_rd); end
        n_cmp++; if (ex_pc !== 32'h308) begin n_bad++; $display("FAIL flush_next_pc got %h want 308", ex_pc); end
        step();
        writeback(5'd9, 32'h0);
        $display("flush dropped entry and offered instr");
    endtask

    task automatic test_illegal();
        ex_ready = 1'b1;
        offer(32'h00000FFF, 32'h400);
        step();
        offer(32'h00500091, 32'h404);
        n_cmp++; if (ex_illegal !== 1'b1) begin n_bad++; $display("FAIL ill7f_flag got %b want 1", ex_illegal); end
        n_cmp++; if (ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL ill7f_regwr got %b want 0", ex_reg_write); end
        n_cmp++; if (ex_opcode !== 5'b11111) begin n_bad++; $display("FAIL ill7f_opcode got %b want 11111", ex_opcode); end
        step();
        offer(32'h000F8513, 32'h408);
        n_cmp++; if (ex_illegal !== 1'b1) begin n_bad++; $display("FAIL illq_flag got %b want 1", ex_illegal); end
        n_cmp++; if (ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL illq_regwr got %b want 0", ex_reg_write); end
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL ill_nobusy got %b want 1", id_ready); end
        step();
        if_valid = 1'b0;
        n_cmp++; if (ex_illegal !== 1'b0) begin n_bad++; $display("FAIL ill_after got %b want 0", ex_illegal); end
        n_cmp++; if (ex_rd !== 5'd10) begin n_bad++; $display("FAIL ill_after_rd got %0d want 10", ex_rd); end
        step();
        writeback(5'd10, 32'h0);
        $display("illegal opcodes decoded");
    endtask

    task automatic test_reset_mid_stall();
        ex_ready = 1'b1;
        offer(32'h00100693, 32'h500);
        step();
        offer(32'h00900613, 32'h504);
        step();
        if_valid = 1'b0; ex_ready = 1'b0;
        n_cmp++; if (ex_rd !== 5'd12) begin n_bad++; $display("FAIL prerst_rd got %0d want 12", ex_rd); end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", ex_valid); end
        n_cmp++; if (ex_operand2 !== 32'h0) begin n_bad++; $display("FAIL rst_op2 got %h want 0", ex_operand2); end
        n_cmp++; if (ex_rd !== 5'd0) begin n_bad++; $display("FAIL rst_rd got %0d want 0", ex_rd); end
        n_cmp++; if (ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL rst_regwr got %b want 0", ex_reg_write); end
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", id_ready); end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid got %b want 0", ex_valid); end
        ex_ready = 1'b1;
        offer(32'h00D08733, 32'h508);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL release_busy got %b want 1", id_ready); end
        step();
        if_valid = 1'b0;
        n_cmp++; if (ex_operand1 !== 32'h0) begin n_bad++; $display("FAIL release_x1 got %h want 0", ex_operand1); end
        n_cmp++; if (ex_rd !== 5'd14) begin n_bad++; $display("FAIL release_rd got %0d want 14", ex_rd); end
        $display("reset mid-stall cleared state");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_raw_hazard();
        test_stall();
        test_branch_store_load();
        test_jal_ex_hazard();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
